// File: rtl/mv_sched_pkg.sv
// Shared types and constants for the matrix-vector job scheduler.
// State encoding, completion status codes and descriptor sizing live here.
package mv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CPL     = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_TAG_W  = 4;
    localparam int STATUS_W   = 2;

    // Descriptor layout is {vec_base, mat_base, out_base, tag}.
    function automatic int desc_width(input int addr_w, input int tag_w);
        return 3 * addr_w + tag_w;
    endfunction

endpackage

// File: rtl/mv_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; the head entry is
// presented combinationally so the scheduler can pop it in the same cycle.
module mv_cmd_fifo #(
    parameter int WIDTH = 100,
    parameter int AW    = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mv_job_scheduler.sv
// Queues matrix-vector job descriptors and runs them one at a time on the
// PE-array engine, with a watchdog, recovery reset and completion handshake.
module mv_job_scheduler
    import mv_sched_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TAG_W       = DEF_TAG_W,
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 65535,
    parameter int RECOVER_CYC = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_vec_base,
    input  logic [ADDR_W-1:0]   cmd_mat_base,
    input  logic [ADDR_W-1:0]   cmd_out_base,
    input  logic [TAG_W-1:0]    cmd_tag,
    output logic                arr_start,
    input  logic                arr_done,
    output logic [ADDR_W-1:0]   arr_vec_base,
    output logic [ADDR_W-1:0]   arr_mat_base,
    output logic [ADDR_W-1:0]   arr_out_base,
    output logic                arr_rst_n,
    output logic                cpl_valid,
    input  logic                cpl_ready,
    output logic [TAG_W-1:0]    cpl_tag,
    output logic [STATUS_W-1:0] cpl_status,
    output logic                busy,
    output logic                irq,
    output logic [31:0]         jobs_done
);

    localparam int DESC_W = desc_width(ADDR_W, TAG_W);
    localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int RC_W   = $clog2(RECOVER_CYC + 1);

    state_t              state_q;
    state_t              state_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [DESC_W-1:0]   fifo_wdata;
    logic [DESC_W-1:0]   fifo_rdata;
    logic [WD_W-1:0]     wdog_q;
    logic [RC_W-1:0]     rec_q;
    logic [TAG_W-1:0]    tag_q;
    logic [STATUS_W-1:0] status_q;
    logic                cpl_seen_q;

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_vec_base, cmd_mat_base, cmd_out_base, cmd_tag};

    mv_cmd_fifo #(
        .WIDTH (DESC_W),
        .AW    (FIFO_AW)
    ) u_cmd_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // A done pulse and an expiring watchdog in the same cycle resolve to OK.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        arr_start = 1'b0;
        arr_rst_n = 1'b1;
        cpl_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                arr_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (arr_done)            state_d = S_CPL;
                else if (wdog_q == '0)   state_d = S_RECOVER;
            end
            S_RECOVER: begin
                arr_rst_n = 1'b0;
                if (rec_q == '0) state_d = S_CPL;
            end
            S_CPL: begin
                cpl_valid = 1'b1;
                if (cpl_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arr_vec_base <= '0;
            arr_mat_base <= '0;
            arr_out_base <= '0;
            tag_q        <= '0;
            status_q     <= ST_OK;
            wdog_q       <= '0;
            rec_q        <= '0;
            jobs_done    <= '0;
            cpl_seen_q   <= 1'b0;
        end else begin
            cpl_seen_q <= (state_q == S_CPL);
            if (fifo_pop)
                {arr_vec_base, arr_mat_base, arr_out_base, tag_q} <= fifo_rdata;
            case (state_q)
                S_ISSUE: wdog_q <= WD_W'(TIMEOUT_CYC);
                S_WAIT: begin
                    if (arr_done) begin
                        status_q <= ST_OK;
                    end else if (wdog_q == '0) begin
                        status_q <= ST_TIMEOUT;
                        rec_q    <= RC_W'(RECOVER_CYC - 1);
                    end else begin
                        wdog_q <= wdog_q - 1'b1;
                    end
                end
                S_RECOVER: if (rec_q != '0) rec_q <= rec_q - 1'b1;
                S_CPL:     if (cpl_ready) jobs_done <= jobs_done + 32'd1;
                default: ;
            endcase
        end
    end

    assign cpl_tag    = tag_q;
    assign cpl_status = status_q;
    assign irq        = (state_q == S_CPL) && !cpl_seen_q;
    assign busy       = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_mv_job_scheduler.sv
// Directed self-checking bench for mv_job_scheduler: single job, FIFO full,
// timeout, done/timeout collision, completion backpressure and mid-job reset.
module tb_mv_job_scheduler;

    localparam int ADDR_W      = 32;
    localparam int TAG_W       = 4;
    localparam int TIMEOUT_CYC = 48;
    localparam int RECOVER_CYC = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_vec_base;
    logic [ADDR_W-1:0] cmd_mat_base;
    logic [ADDR_W-1:0] cmd_out_base;
    logic [TAG_W-1:0]  cmd_tag;
    logic              arr_start;
    logic              arr_done;
    logic [ADDR_W-1:0] arr_vec_base;
    logic [ADDR_W-1:0] arr_mat_base;
    logic [ADDR_W-1:0] arr_out_base;
    logic              arr_rst_n;
    logic              cpl_valid;
    logic              cpl_ready;
    logic [TAG_W-1:0]  cpl_tag;
    logic [1:0]        cpl_status;
    logic              busy;
    logic              irq;
    logic [31:0]       jobs_done;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    mv_job_scheduler #(
        .ADDR_W      (ADDR_W),
        .TAG_W       (TAG_W),
        .FIFO_AW     (2),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RECOVER_CYC (RECOVER_CYC)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_vec_base (cmd_vec_base),
        .cmd_mat_base (cmd_mat_base),
        .cmd_out_base (cmd_out_base),
        .cmd_tag      (cmd_tag),
        .arr_start    (arr_start),
        .arr_done     (arr_done),
        .arr_vec_base (arr_vec_base),
        .arr_mat_base (arr_mat_base),
        .arr_out_base (arr_out_base),
        .arr_rst_n    (arr_rst_n),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_tag      (cpl_tag),
        .cpl_status   (cpl_status),
        .busy         (busy),
        .irq          (irq),
        .jobs_done    (jobs_done)
    );

    function automatic logic [31:0] vecOf(input int t);
        return 32'h0000_1000 + 32'(t);
    endfunction
    function automatic logic [31:0] matOf(input int t);
        return 32'h0000_2000 + 32'(t);
    endfunction
    function automatic logic [31:0] outOf(input int t);
        return 32'h0000_3000 + 32'(t);
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [TAG_W-1:0] tag,
                                 input logic [31:0] vec, input logic [31:0] mat,
                                 input logic [31:0] out);
        cmd_valid    = valid;
        cmd_tag      = tag;
        cmd_vec_base = vec;
        cmd_mat_base = mat;
        cmd_out_base = out;
    endtask

    task automatic clearStimulus();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        while (arr_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput(name, 32'(arr_start), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int extra;
        int low;
        int n;
        int bad;

        aresetn   = 1'b0;
        arr_done  = 1'b0;
        cpl_ready = 1'b0;
        clearStimulus();
        step();
        step();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_arr_rst_n", 32'(arr_rst_n), 32'd1);
        checkOutput("rst_arr_start", 32'(arr_start), 32'd0);
        checkOutput("rst_cpl_valid", 32'(cpl_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_jobs_done", jobs_done, 32'd0);
        checkOutput("rst_vec_base", arr_vec_base, 32'd0);
        aresetn = 1'b1;
        step();

        $display("[TB] single job");
        cpl_ready = 1'b1;
        applyStimulus(1'b1, 4'd3, 32'h0000_0000, 32'h0000_0100, 32'h0000_4000);
        step();
        clearStimulus();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_no_early_start", 32'(arr_start), 32'd0);
        step();
        checkOutput("t1_start", 32'(arr_start), 32'd1);
        checkOutput("t1_vec", arr_vec_base, 32'h0000_0000);
        checkOutput("t1_mat", arr_mat_base, 32'h0000_0100);
        checkOutput("t1_out", arr_out_base, 32'h0000_4000);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (arr_start) extra++;
        end
        checkOutput("t1_single_start", 32'(extra), 32'd0);
        checkOutput("t1_out_held", arr_out_base, 32'h0000_4000);
        checkOutput("t1_mat_held", arr_mat_base, 32'h0000_0100);
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        checkOutput("t1_cpl_valid", 32'(cpl_valid), 32'd1);
        checkOutput("t1_cpl_tag", 32'(cpl_tag), 32'd3);
        checkOutput("t1_cpl_status", 32'(cpl_status), 32'd0);
        checkOutput("t1_irq", 32'(irq), 32'd1);
        step();
        checkOutput("t1_cpl_cleared", 32'(cpl_valid), 32'd0);
        checkOutput("t1_irq_cleared", 32'(irq), 32'd0);
        checkOutput("t1_jobs_done", jobs_done, 32'd1);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        $display("[TB] FIFO full");
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, 4'(j), vecOf(j), matOf(j), outOf(j));
            step();
            checkOutput("t2_ready_after_push", 32'(cmd_ready), (j < 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 4'd5, vecOf(5), matOf(5), outOf(5));
        step();
        step();
        clearStimulus();
        checkOutput("t2_full_holds", 32'(cmd_ready), 32'd0);
        checkOutput("t2_job0_vec", arr_vec_base, vecOf(0));
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        checkOutput("t2_cpl_valid", 32'(cpl_valid), 32'd1);
        checkOutput("t2_cpl_tag", 32'(cpl_tag), 32'd0);
        for (int j = 1; j < 5; j++) begin
            waitStart("t2_start");
            checkOutput("t2_job_vec", arr_vec_base, vecOf(j));
            step();
            step();
            arr_done = 1'b1;
            step();
            arr_done = 1'b0;
            checkOutput("t2_cpl_valid", 32'(cpl_valid), 32'd1);
            checkOutput("t2_cpl_tag", 32'(cpl_tag), 32'(j));
            checkOutput("t2_cpl_status", 32'(cpl_status), 32'd0);
        end
        step();
        checkOutput("t2_jobs_done", jobs_done, 32'd6);
        checkOutput("t2_idle", 32'(busy), 32'd0);

        $display("[TB] timeout");
        applyStimulus(1'b1, 4'd7, vecOf(7), matOf(7), outOf(7));
        step();
        clearStimulus();
        waitStart("t3_start");
        low = 0;
        n   = 0;
        while (cpl_valid !== 1'b1 && n < 200) begin
            step();
            n++;
            if (!arr_rst_n) low++;
        end
        checkOutput("t3_cycles_to_cpl", 32'(n), 32'd58);
        checkOutput("t3_rst_low_cycles", 32'(low), 32'd8);
        checkOutput("t3_cpl_valid", 32'(cpl_valid), 32'd1);
        checkOutput("t3_cpl_status", 32'(cpl_status), 32'd1);
        checkOutput("t3_cpl_tag", 32'(cpl_tag), 32'd7);
        checkOutput("t3_irq", 32'(irq), 32'd1);
        step();
        checkOutput("t3_jobs_done", jobs_done, 32'd7);
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        step();
        checkOutput("t3_late_done_cpl", 32'(cpl_valid), 32'd0);
        checkOutput("t3_late_done_busy", 32'(busy), 32'd0);
        checkOutput("t3_late_done_jobs", jobs_done, 32'd7);

        $display("[TB] done/timeout collision");
        applyStimulus(1'b1, 4'd9, vecOf(9), matOf(9), outOf(9));
        step();
        clearStimulus();
        waitStart("t4_start");
        low = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (!arr_rst_n) low++;
        end
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        checkOutput("t4_cpl_valid", 32'(cpl_valid), 32'd1);
        checkOutput("t4_cpl_status", 32'(cpl_status), 32'd0);
        checkOutput("t4_cpl_tag", 32'(cpl_tag), 32'd9);
        checkOutput("t4_rst_never_low", 32'(low), 32'd0);
        checkOutput("t4_arr_rst_n", 32'(arr_rst_n), 32'd1);
        step();
        checkOutput("t4_jobs_done", jobs_done, 32'd8);

        $display("[TB] completion backpressure");
        cpl_ready = 1'b0;
        applyStimulus(1'b1, 4'd10, vecOf(10), matOf(10), outOf(10));
        step();
        applyStimulus(1'b1, 4'd11, vecOf(11), matOf(11), outOf(11));
        step();
        clearStimulus();
        waitStart("t5_start");
        step();
        step();
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        checkOutput("t5_cpl_valid", 32'(cpl_valid), 32'd1);
        checkOutput("t5_cpl_tag", 32'(cpl_tag), 32'd10);
        checkOutput("t5_irq", 32'(irq), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpl_valid !== 1'b1 || cpl_tag !== 4'd10 || cpl_status !== 2'd0 ||
                arr_start !== 1'b0 || irq !== 1'b0)
                bad++;
        end
        checkOutput("t5_hold_stable", 32'(bad), 32'd0);
        cpl_ready = 1'b1;
        step();
        checkOutput("t5_cpl_cleared", 32'(cpl_valid), 32'd0);
        checkOutput("t5_jobs_done", jobs_done, 32'd9);
        checkOutput("t5_no_start_yet", 32'(arr_start), 32'd0);
        step();
        checkOutput("t5_second_start", 32'(arr_start), 32'd1);
        checkOutput("t5_second_vec", arr_vec_base, vecOf(11));

        $display("[TB] reset mid-job");
        step();
        applyStimulus(1'b1, 4'd12, vecOf(12), matOf(12), outOf(12));
        step();
        applyStimulus(1'b1, 4'd13, vecOf(13), matOf(13), outOf(13));
        step();
        clearStimulus();
        checkOutput("t6_busy_before", 32'(busy), 32'd1);
        aresetn = 1'b0;
        step();
        checkOutput("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_arr_rst_n", 32'(arr_rst_n), 32'd1);
        checkOutput("t6_arr_start", 32'(arr_start), 32'd0);
        checkOutput("t6_cpl_valid", 32'(cpl_valid), 32'd0);
        checkOutput("t6_irq", 32'(irq), 32'd0);
        checkOutput("t6_jobs_done", jobs_done, 32'd0);
        checkOutput("t6_vec_base", arr_vec_base, 32'd0);
        checkOutput("t6_cpl_tag", 32'(cpl_tag), 32'd0);
        aresetn = 1'b1;
        step();
        step();
        checkOutput("t6_fifo_cleared", 32'(busy), 32'd0);
        checkOutput("t6_no_start", 32'(arr_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
